// File: rtl/run_det_pkg.sv
// Shared types and default parameters for the run-length detector.
// The optional match counter is enabled with the RUN_DET_MATCH_CNT_EN macro.
package run_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2
    } state_t;

    localparam int DEF_RUN_LEN = 3;
    localparam int DEF_OVERLAP = 1;
    localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/run_len_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [width-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/run_len_detector.sv
// Serial run-length detector: Moore output z flags RUN_LEN consecutive valid samples equal to pol.
// Define RUN_DET_MATCH_CNT_EN to add the saturating match_cnt output and its clr_cnt control.
module run_len_detector
    import run_det_pkg::*;
#(
    parameter int RUN_LEN = DEF_RUN_LEN,
    parameter int OVERLAP = DEF_OVERLAP,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         x_valid,
    input  logic                         x,
    input  logic                         pol,
    input  logic                         clr_cnt,
    output logic                         z,
    output logic [$clog2(RUN_LEN+1)-1:0] run_cnt
`ifdef RUN_DET_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]             match_cnt
`endif
);

    localparam int RC_W = $clog2(RUN_LEN + 1);
    localparam logic [RC_W-1:0] ONE       = RC_W'(1);
    localparam logic [RC_W-1:0] RUN_LEN_V = RC_W'(RUN_LEN);

    state_t          state, state_nxt;
    logic [RC_W-1:0] run_cnt_nxt;
    logic            det;

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous, so it lives inside the clocked branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            run_cnt <= '0;
            z       <= 1'b0;
        end else begin
            state   <= state_nxt;
            run_cnt <= run_cnt_nxt;
            z       <= (state_nxt == HIT);
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        run_cnt_nxt = run_cnt;
        det         = 1'b0;
        case (state)
            IDLE, RUN, HIT: begin
                if (x_valid) begin
                    if (x != pol) begin
                        state_nxt   = IDLE;
                        run_cnt_nxt = '0;
                    end else if (state == IDLE) begin
                        state_nxt   = RUN;
                        run_cnt_nxt = ONE;
                    end else if (state == RUN) begin
                        if (run_cnt >= RUN_LEN_V - ONE) begin
                            state_nxt   = HIT;
                            run_cnt_nxt = RUN_LEN_V;
                            det         = 1'b1;
                        end else begin
                            run_cnt_nxt = run_cnt + ONE;
                        end
                    end else if (OVERLAP != 0) begin
                        // Each further match while saturated is a fresh detection.
                        run_cnt_nxt = RUN_LEN_V;
                        det         = 1'b1;
                    end else begin
                        state_nxt   = RUN;
                        run_cnt_nxt = ONE;
                    end
                end
            end
            default: begin
                state_nxt   = IDLE;
                run_cnt_nxt = '0;
            end
        endcase
    end

`ifdef RUN_DET_MATCH_CNT_EN
    sat_counter #(
        .width(CNT_W)
    ) u_match_cnt (
        .clk(clk),
        .rst(rst),
        .inc(det),
        .clr(clr_cnt),
        .cnt(match_cnt)
    );
`else
    logic unused_ok;
    assign unused_ok = clr_cnt ^ det ^ (CNT_W > 0);
`endif

endmodule

// File: tb/tb_run_len_detector.sv
// Self-checking bench: four detector configurations share one stimulus stream,
// checked against directed vectors and an arithmetic run-length reference model.
module tb_run_len_detector;

    logic clk = 1'b0;
    logic rst, x_valid, x, pol, clr_cnt;

    logic       z0, z1, z2, z3;
    logic [1:0] rc0, rc1, rc2;
    logic [2:0] rc3;
`ifdef RUN_DET_MATCH_CNT_EN
    logic [7:0] m0, m1;
    logic [1:0] m2;
    logic [3:0] m3;
`endif

    always #5 clk = ~clk;

    // k=0: L3 overlap W8, k=1: L3 non-overlap W8, k=2: L3 overlap W2, k=3: L5 non-overlap W4
    run_len_detector #(.RUN_LEN(3), .OVERLAP(1), .CNT_W(8)) u_ov (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .pol(pol), .clr_cnt(clr_cnt),
        .z(z0), .run_cnt(rc0)
`ifdef RUN_DET_MATCH_CNT_EN
        , .match_cnt(m0)
`endif
    );
    run_len_detector #(.RUN_LEN(3), .OVERLAP(0), .CNT_W(8)) u_no (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .pol(pol), .clr_cnt(clr_cnt),
        .z(z1), .run_cnt(rc1)
`ifdef RUN_DET_MATCH_CNT_EN
        , .match_cnt(m1)
`endif
    );
    run_len_detector #(.RUN_LEN(3), .OVERLAP(1), .CNT_W(2)) u_c2 (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .pol(pol), .clr_cnt(clr_cnt),
        .z(z2), .run_cnt(rc2)
`ifdef RUN_DET_MATCH_CNT_EN
        , .match_cnt(m2)
`endif
    );
    run_len_detector #(.RUN_LEN(5), .OVERLAP(0), .CNT_W(4)) u_l5 (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .pol(pol), .clr_cnt(clr_cnt),
        .z(z3), .run_cnt(rc3)
`ifdef RUN_DET_MATCH_CNT_EN
        , .match_cnt(m3)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: run = number of consecutive matching valid samples since the last break or reset.
    int run = 0;
    int mc[4] = '{0, 0, 0, 0};

    function automatic int cfg_l(input int k);
        return (k == 3) ? 5 : 3;
    endfunction
    function automatic bit cfg_ov(input int k);
        return (k == 0) || (k == 2);
    endfunction
    function automatic int cfg_max(input int k);
        case (k)
            2:       return 3;
            3:       return 15;
            default: return 255;
        endcase
    endfunction

    function automatic int exp_z(input int k);
        if (run == 0) return 0;
        if (cfg_ov(k)) return (run >= cfg_l(k)) ? 1 : 0;
        return (run % cfg_l(k) == 0) ? 1 : 0;
    endfunction
    function automatic int exp_rc(input int k);
        if (run == 0) return 0;
        if (cfg_ov(k)) return (run < cfg_l(k)) ? run : cfg_l(k);
        return ((run - 1) % cfg_l(k)) + 1;
    endfunction

    task automatic model_update(input bit r, input bit v, input bit xi, input bit p, input bit c);
        bit hit;
        if (r) begin
            run = 0;
            for (int k = 0; k < 4; k++) mc[k] = 0;
        end else begin
            if (v) run = (xi == p) ? run + 1 : 0;
            for (int k = 0; k < 4; k++) begin
                hit = v && (xi == p) && (exp_z(k) == 1);
                if (c) mc[k] = 0;
                else if (hit && mc[k] < cfg_max(k)) mc[k] = mc[k] + 1;
            end
        end
    endtask

    task automatic compare_all();
        check("z_ov",  int'(z0),  exp_z(0));
        check("z_no",  int'(z1),  exp_z(1));
        check("z_c2",  int'(z2),  exp_z(2));
        check("z_l5",  int'(z3),  exp_z(3));
        check("rc_ov", int'(rc0), exp_rc(0));
        check("rc_no", int'(rc1), exp_rc(1));
        check("rc_c2", int'(rc2), exp_rc(2));
        check("rc_l5", int'(rc3), exp_rc(3));
`ifdef RUN_DET_MATCH_CNT_EN
        check("mc_ov", int'(m0), mc[0]);
        check("mc_no", int'(m1), mc[1]);
        check("mc_c2", int'(m2), mc[2]);
        check("mc_l5", int'(m3), mc[3]);
`endif
    endtask

    task automatic step(input bit r, input bit v, input bit xi, input bit p, input bit c);
        rst     = r;
        x_valid = v;
        x       = xi;
        pol     = p;
        clr_cnt = c;
        @(posedge clk);
        #1;
        model_update(r, v, xi, p, c);
        compare_all();
    endtask

    typedef struct {
        bit r, v, xi, p, c;
        bit z_ov, z_no;
        int rc_ov, rc_no;
    } vec_t;

    vec_t tbl[$];

    initial begin
        rst = 1'b1; x_valid = 1'b0; x = 1'b0; pol = 1'b1; clr_cnt = 1'b0;

        //          r  v  x  p  c  zov zno rov rno
        tbl.push_back('{1, 0, 0, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 1, 0, 0, 0, 1, 1});
        tbl.push_back('{0, 1, 1, 1, 0, 0, 0, 2, 2});
        tbl.push_back('{0, 1, 1, 1, 0, 1, 1, 3, 3});
        tbl.push_back('{0, 1, 1, 1, 0, 1, 0, 3, 1});
        tbl.push_back('{0, 1, 1, 1, 0, 1, 0, 3, 2});
        tbl.push_back('{0, 1, 1, 1, 0, 1, 1, 3, 3});
        tbl.push_back('{0, 1, 0, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 1, 0, 0, 0, 1, 1});
        for (int i = 0; i < 4; i++) tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 1, 1});
        tbl.push_back('{0, 1, 1, 1, 0, 0, 0, 2, 2});
        tbl.push_back('{0, 1, 1, 1, 0, 1, 1, 3, 3});
        tbl.push_back('{0, 1, 0, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 1, 0, 0, 0, 1, 1});
        tbl.push_back('{0, 1, 1, 1, 0, 0, 0, 2, 2});
        tbl.push_back('{0, 1, 0, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 1, 0, 0, 0, 1, 1});
        tbl.push_back('{0, 1, 1, 1, 0, 0, 0, 2, 2});
        tbl.push_back('{0, 1, 1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 1, 1});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 2, 2});
        tbl.push_back('{0, 1, 0, 0, 0, 1, 1, 3, 3});
        tbl.push_back('{0, 1, 1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 1, 0, 0, 0, 1, 1});
        tbl.push_back('{0, 1, 1, 1, 0, 0, 0, 2, 2});
        tbl.push_back('{1, 1, 1, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 1, 0, 0, 0, 1, 1});
        tbl.push_back('{0, 1, 1, 1, 0, 0, 0, 2, 2});
        tbl.push_back('{0, 1, 1, 1, 0, 1, 1, 3, 3});
        tbl.push_back('{0, 0, 0, 1, 0, 1, 1, 3, 3});

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].v, tbl[i].xi, tbl[i].p, tbl[i].c);
            check($sformatf("tbl%0d_z_ov", i),  int'(z0),  int'(tbl[i].z_ov));
            check($sformatf("tbl%0d_z_no", i),  int'(z1),  int'(tbl[i].z_no));
            check($sformatf("tbl%0d_rc_ov", i), int'(rc0), tbl[i].rc_ov);
            check($sformatf("tbl%0d_rc_no", i), int'(rc1), tbl[i].rc_no);
        end

        // Clear coinciding with a detection, then saturation of the 2-bit counter.
        step(1, 0, 0, 1, 0);
        step(0, 1, 1, 1, 0);
        step(0, 1, 1, 1, 0);
        step(0, 1, 1, 1, 1);
        check("clr_det_z", int'(z0), 1);
`ifdef RUN_DET_MATCH_CNT_EN
        check("clr_det_mc", int'(m0), 0);
`endif
        for (int i = 0; i < 5; i++) step(0, 1, 1, 1, 0);
        check("sat_z", int'(z2), 1);
`ifdef RUN_DET_MATCH_CNT_EN
        check("sat_mc_c2", int'(m2), 3);
        check("sat_mc_ov", int'(m0), 5);
`endif

        // Randomised stream against the reference model.
        begin
            bit p;
            p = 1'b1;
            for (int i = 0; i < 3000; i++) begin
                bit r, v, xi, c;
                if ($urandom_range(15) == 0) p = ~p;
                r  = ($urandom_range(99) == 0);
                v  = ($urandom_range(4) != 0);
                xi = ($urandom_range(3) != 0) ? p : ~p;
                c  = ($urandom_range(19) == 0);
                step(r, v, xi, p, c);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
